// File: rtl/mem_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_pkg
// Shared types and constants for the memory/bus controller:
//   - mbc_state_e : controller FSM states
//   - mbc_port_e  : which pipeline port currently owns the grant
//   - IO_SPACE_BIT, ZERO_WORD, LAT_CNT_W
//   - is_io_addr(): address decoder for the memory-mapped I/O space
// -----------------------------------------------------------------------------
package mem_bus_ctrl_pkg;

    localparam int          IO_SPACE_BIT = 31;
    localparam int          LAT_CNT_W    = 3;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        MBC_IDLE     = 2'd0,
        MBC_RAM_ACC  = 2'd1,
        MBC_RAM_WAIT = 2'd2,
        MBC_RESP     = 2'd3
    } mbc_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } mbc_port_e;

    // True when the byte address falls in the memory-mapped I/O window.
    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[IO_SPACE_BIT];
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_if
// Bundles the fetch port, the data port and the RAM macro port of the
// memory/bus controller.
//   slave  : the controller's view (takes requests, drives acks and the RAM)
//   master : the surroundings' view (pipeline stages issue requests, RAM
//            returns read data)
// Parameter RAM_AW sets the RAM word-address width.
// -----------------------------------------------------------------------------
interface mem_bus_ctrl_if #(
    parameter int RAM_AW = 10
);
    // fetch port
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    // data port
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    // RAM macro
    logic              ram_ce;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output ram_ce, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  ram_ce, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_bus_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_sync2
// Parameterised-width two-flop synchronizer for slow asynchronous inputs
// (the board DIP switches). Output lags the input by two clock edges.
// Ports:
//   clk  in  1      system clock
//   rst  in  1      synchronous active-high reset, clears both stages
//   d_i  in  WIDTH  asynchronous input
//   q_o  out WIDTH  synchronized output
// -----------------------------------------------------------------------------
module mem_bus_ctrl_sync2 #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back capture stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Owns the single-port unified RAM and the memory-mapped I/O (switches, LEDs).
// Arbitrates the IF fetch port against the MEM data port (data wins), runs
// multi-cycle RAM reads and raises a pipeline stall while a request is open.
// Parameters:
//   RAM_AW   RAM word-address width (2**RAM_AW 32-bit words)
//   RAM_LAT  RAM read latency in cycles after ram_ce (1..7)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           fetch/data/RAM bundle, slave side
//   switch_on_i   asynchronous DIP switches (12 bits)
//   led_out_o     LED register (12 bits)
//   stall_req_o   request pending and not acknowledged this cycle
// -----------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_ctrl_if.slave   bus,
    input  logic [11:0]     switch_on_i,
    output logic [11:0]     led_out_o,
    output logic            stall_req_o
);

    // Last RAM_WAIT count value; a latency of 1 captures on the first wait cycle.
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RAM_LAT - 1);

    mbc_state_e           state_q;
    mbc_port_e            gnt_port_q;
    logic                 gnt_we_q;
    logic [LAT_CNT_W-1:0] lat_cnt_q;
    logic [31:0]          if_rdata_q;
    logic                 if_ack_q;
    logic [31:0]          d_rdata_q;
    logic                 d_ack_q;
    logic                 ram_ce_q;
    logic                 ram_we_q;
    logic [RAM_AW-1:0]    ram_addr_q;
    logic [31:0]          ram_wdata_q;
    logic [11:0]          led_q;
    logic [11:0]          sw_sync_s;
    logic                 unused_addr_bits_s;

    mem_bus_ctrl_sync2 #(
        .WIDTH (12)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d_i (switch_on_i),
        .q_o (sw_sync_s)
    );

    // Controller FSM with grant, latency counter, LED and all bus outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MBC_IDLE;
            gnt_port_q  <= PORT_IF;
            gnt_we_q    <= 1'b0;
            lat_cnt_q   <= '0;
            if_rdata_q  <= ZERO_WORD;
            if_ack_q    <= 1'b0;
            d_rdata_q   <= ZERO_WORD;
            d_ack_q     <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= ZERO_WORD;
            led_q       <= 12'h000;
        end else begin
            // Acks and RAM strobes are single-cycle unless re-armed below.
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            ram_ce_q <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                MBC_IDLE: begin
                    if (bus.d_req) begin
                        gnt_port_q <= PORT_D;
                        gnt_we_q   <= bus.d_we;
                        if (is_io_addr(bus.d_addr)) begin
                            // I/O completes without touching the RAM.
                            state_q <= MBC_RESP;
                            d_ack_q <= 1'b1;
                            if (bus.d_we) begin
                                led_q <= bus.d_wdata[11:0];
                            end else begin
                                d_rdata_q <= {20'd0, sw_sync_s};
                            end
                        end else begin
                            state_q     <= MBC_RAM_ACC;
                            ram_ce_q    <= 1'b1;
                            ram_we_q    <= bus.d_we;
                            ram_addr_q  <= bus.d_addr[RAM_AW+1:2];
                            ram_wdata_q <= bus.d_wdata;
                        end
                    end else if (bus.if_req) begin
                        gnt_port_q <= PORT_IF;
                        gnt_we_q   <= 1'b0;
                        if (is_io_addr(bus.if_addr)) begin
                            // Nothing executable lives in I/O space; return zero.
                            state_q    <= MBC_RESP;
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= ZERO_WORD;
                        end else begin
                            state_q    <= MBC_RAM_ACC;
                            ram_ce_q   <= 1'b1;
                            ram_addr_q <= bus.if_addr[RAM_AW+1:2];
                        end
                    end else begin
                        state_q <= MBC_IDLE;
                    end
                end
                MBC_RAM_ACC: begin
                    if (gnt_we_q) begin
                        state_q <= MBC_RESP;
                        d_ack_q <= 1'b1;
                    end else begin
                        state_q   <= MBC_RAM_WAIT;
                        lat_cnt_q <= '0;
                    end
                end
                MBC_RAM_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q <= MBC_RESP;
                        if (gnt_port_q == PORT_D) begin
                            d_rdata_q <= bus.ram_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.ram_rdata;
                            if_ack_q   <= 1'b1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + {{(LAT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                MBC_RESP: begin
                    state_q <= MBC_IDLE;
                end
                default: begin
                    state_q <= MBC_IDLE;
                end
            endcase
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.ram_ce    = ram_ce_q;
    // A store whose RAM_ACC cycle coincides with reset must not reach the array.
    assign bus.ram_we    = ram_we_q & ~rst;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign led_out_o     = led_q;
    assign stall_req_o   = (bus.if_req | bus.d_req) & ~(if_ack_q | d_ack_q);

    // Byte-lane and wrap-around address bits are deliberately ignored.
    assign unused_addr_bits_s = ^{bus.if_addr[30:RAM_AW+2], bus.if_addr[1:0],
                                  bus.d_addr[30:RAM_AW+2],  bus.d_addr[1:0]};

endmodule
